id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode/issue stage that sits between the IF/ID latch and the execute stage, directly around the register bank.
- Drives the register bank read pointers and applies write-back bypass to the returned operands.
- Detects load-use hazards and inserts bubbles; honours flush and downstream hold.
- Registers everything into the ID/EX pipeline register consumed by execute.

Parameters:
- N, 32, number of architectural registers; register 0 is hard zero.
- Bits, 64, datapath width.
- CTRL_W, 8, control bundle width: bit0 reg_write, bit1 mem_read, bit2 mem_write, bit3 alu_src, bits7:4 alu_op.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_rs1, if_rs2, if_rd  in  $clog2(N)  source and destination register indices.
- if_use_rs2  in  1  instruction reads rs2; excludes I-type/load from the hazard compare.
- if_imm  in  Bits  sign-extended immediate.
- if_ctrl  in  CTRL_W  decoded control bundle.
- id_stall  out  1  holds IF/ID and the PC this cycle.
- rf_ptr_rd_1, rf_ptr_rd_2  out  $clog2(N)  register bank read pointers.
- rf_data_rd_1, rf_data_rd_2  in  Bits  register bank read data.
- wb_wr_en  in  1  write-back write enable; same signal as the register bank write port.
- wb_ptr_wr  in  $clog2(N)  write-back destination register.
- wb_data_wr  in  Bits  write-back data.
- flush  in  1  branch taken or redirect; kill the instruction in ID.
- ex_hold  in  1  execute cannot accept; freeze ID/EX.
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_rs1_data, ex_rs2_data  out  Bits  registered operands.
- ex_rs1, ex_rs2, ex_rd  out  $clog2(N)  registered indices, used by forwarding in EX.
- ex_imm  out  Bits  registered immediate.
- ex_ctrl  out  CTRL_W  registered control bundle.
- bubble_cnt  out  CNT_W  count of inserted bubbles.

Behaviour:
- rf_ptr_rd_1 = if_rs1 and rf_ptr_rd_2 = if_rs2, combinational, zero latency.
- Operand select, combinational:
  - index 0 always yields 0.
  - else if wb_wr_en and wb_ptr_wr == index, yields wb_data_wr (write-through bypass).
  - else yields rf_data.
- load_use = if_valid & ex_valid & ex_ctrl.mem_read & ex_rd != 0 & (ex_rd == if_rs1 | (if_use_rs2 & ex_rd == if_rs2)).
- id_stall = (load_use | ex_hold) & ~flush.
- Next ID/EX state, evaluated at posedge with priority top to bottom:
  1. rst (async): ex_valid=0, ex_ctrl=0, all data and index outputs 0, bubble_cnt=0.
  2. flush: ex_valid=0, ex_ctrl=0; other fields don't-care and hold. Overrides ex_hold, so a held instruction is killed.
  3. ex_hold: all ID/EX fields hold.
  4. load_use: bubble inserted (ex_valid=0, ex_ctrl=0); bubble_cnt += 1.
  5. otherwise: capture if_valid, the selected operands, indices, imm and ctrl. When if_valid=0, ex_ctrl is forced to 0.
- Latency: one cycle from IF/ID to ID/EX.
- A load-use stall lasts exactly 1 cycle. The next cycle ex_valid=0, load_use deasserts, and the instruction issues.
- bubble_cnt saturates at all-ones and does not wrap. Flush cycles are not counted.
- A reset asserted mid-stall clears state immediately. id_stall returns to 0 once rst releases, since ex_valid=0.
- Bubbles never set reg_write or mem_write.

Decomposition:
- Shared package pipeline_pkg holds:
  - CTRL_W and the bit-position constants CTRL_REG_WRITE, CTRL_MEM_READ, CTRL_MEM_WRITE, CTRL_ALU_SRC, CTRL_ALU_OP_LSB/MSB.
  - the ctrl_t packed struct.
  - localparam CTRL_NOP = 0.
- One sub-module, load_use_detect (combinational): hazard compare producing load_use.
- Operand bypass muxes and ID/EX registers stay in id_ex_stage.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 -> all outputs 0 immediately; after release with if_valid=1, rs1=5, rf_data_rd_1=0x11 -> next edge ex_valid=1, ex_rs1_data=0x11.
- Bypass: rs1=7, rf_data_rd_1=0xAA, wb_wr_en=1, wb_ptr_wr=7, wb_data_wr=0xBB -> ex_rs1_data=0xBB. Repeat with rs1=0 and wb_ptr_wr=0 -> ex_rs1_data=0.
- Load-use: ld x3 in EX (mem_read=1, rd=3), ID add with rs2=3 -> id_stall=1 for one cycle, ex_valid=0, ex_ctrl=0, bubble_cnt=1. Next edge the add issues. Same case with if_use_rs2=0 -> no stall.
- Flush vs hold: ex_hold=1 with a valid instruction in ID/EX for 3 cycles -> outputs frozen, id_stall=1. Then flush=1 together with ex_hold=1 -> ex_valid=0 next edge and id_stall=0.
- Load to x0: ld with rd=0 in EX, ID rs1=0 -> no stall, bubble_cnt unchanged.
- Saturation: force 2^16+3 load-use events -> bubble_cnt=0xFFFF and it stays there.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the decode/issue slice.
// Holds the control bundle layout (bit positions and packed struct) and
// the all-zero NOP control word used for bubbles and killed slots.
package pipeline_pkg;

  localparam int CTRL_W          = 8;
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_ALU_OP_LSB = 4;
  localparam int CTRL_ALU_OP_MSB = 7;

  // Declared MSB first so reg_write lands on bit 0.
  typedef struct packed {
    logic [CTRL_ALU_OP_MSB-CTRL_ALU_OP_LSB:0] alu_op;
    logic                                     alu_src;
    logic                                     mem_write;
    logic                                     mem_read;
    logic                                     reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus bundle around the decode/issue stage: IF/ID inputs, register bank
// read port, write-back port, flush/hold controls and the ID/EX register
// outputs.
//   slave  : the id_ex_stage itself
//   master : the surrounding pipeline (fetch, register bank, WB, EX)
// Handshake: there is no valid/ready pair. if_valid qualifies the IF/ID
// contents; id_stall tells fetch to hold IF/ID and the PC; ex_hold tells
// the stage that execute cannot accept, so ID/EX freezes; ex_valid
// qualifies the ID/EX contents.
interface id_ex_stage_if
  import pipeline_pkg::*;
#(
  parameter int N     = 32,
  parameter int Bits  = 64,
  parameter int CNT_W = 16
);
  localparam int IDX_W = $clog2(N);

  logic             if_valid;
  logic [IDX_W-1:0] if_rs1;
  logic [IDX_W-1:0] if_rs2;
  logic [IDX_W-1:0] if_rd;
  logic             if_use_rs2;
  logic [Bits-1:0]  if_imm;
  ctrl_t            if_ctrl;
  logic             id_stall;
  logic [IDX_W-1:0] rf_ptr_rd_1;
  logic [IDX_W-1:0] rf_ptr_rd_2;
  logic [Bits-1:0]  rf_data_rd_1;
  logic [Bits-1:0]  rf_data_rd_2;
  logic             wb_wr_en;
  logic [IDX_W-1:0] wb_ptr_wr;
  logic [Bits-1:0]  wb_data_wr;
  logic             flush;
  logic             ex_hold;
  logic             ex_valid;
  logic [Bits-1:0]  ex_rs1_data;
  logic [Bits-1:0]  ex_rs2_data;
  logic [IDX_W-1:0] ex_rs1;
  logic [IDX_W-1:0] ex_rs2;
  logic [IDX_W-1:0] ex_rd;
  logic [Bits-1:0]  ex_imm;
  ctrl_t            ex_ctrl;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output if_valid, if_rs1, if_rs2, if_rd, if_use_rs2, if_imm, if_ctrl,
    output rf_data_rd_1, rf_data_rd_2, wb_wr_en, wb_ptr_wr, wb_data_wr,
    output flush, ex_hold,
    input  id_stall, rf_ptr_rd_1, rf_ptr_rd_2, ex_valid, ex_rs1_data,
    input  ex_rs2_data, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_ctrl, bubble_cnt
  );

  modport slave (
    input  if_valid, if_rs1, if_rs2, if_rd, if_use_rs2, if_imm, if_ctrl,
    input  rf_data_rd_1, rf_data_rd_2, wb_wr_en, wb_ptr_wr, wb_data_wr,
    input  flush, ex_hold,
    output id_stall, rf_ptr_rd_1, rf_ptr_rd_2, ex_valid, ex_rs1_data,
    output ex_rs2_data, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_ctrl, bubble_cnt
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard compare.
// Ports:
//   i_if_valid, i_if_rs1, i_if_rs2, i_if_use_rs2 : instruction in ID
//   i_ex_valid, i_ex_mem_read, i_ex_rd           : instruction in ID/EX
//   o_load_use                                   : ID must wait one cycle
module load_use_detect #(
  parameter int IDX_W = 5
) (
  input  logic             i_if_valid,
  input  logic [IDX_W-1:0] i_if_rs1,
  input  logic [IDX_W-1:0] i_if_rs2,
  input  logic             i_if_use_rs2,
  input  logic             i_ex_valid,
  input  logic             i_ex_mem_read,
  input  logic [IDX_W-1:0] i_ex_rd,
  output logic             o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = (i_ex_rd == i_if_rs1);
  // I-type and loads carry an immediate in the rs2 field; ignore it.
  assign w_rs2_hit = i_if_use_rs2 && (i_ex_rd == i_if_rs2);

  // A load to x0 produces nothing anyone can depend on.
  assign o_load_use = i_if_valid && i_ex_valid && i_ex_mem_read &&
                      (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue stage between the IF/ID latch and execute.
// Drives the register bank read pointers, applies write-back bypass to
// the returned operands, inserts a one-cycle bubble on load-use, honours
// flush and execute hold, and registers the result into ID/EX.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : id_ex_stage_if slave (IF/ID in, RF read, WB, flush/hold,
//              ID/EX out, bubble counter)
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int N     = 32,
  parameter int Bits  = 64,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  localparam int IDX_W = $clog2(N);

  logic             w_load_use;
  logic [Bits-1:0]  w_op1;
  logic [Bits-1:0]  w_op2;

  logic             r_ex_valid;
  ctrl_t            r_ex_ctrl;
  logic [Bits-1:0]  r_ex_rs1_data;
  logic [Bits-1:0]  r_ex_rs2_data;
  logic [IDX_W-1:0] r_ex_rs1;
  logic [IDX_W-1:0] r_ex_rs2;
  logic [IDX_W-1:0] r_ex_rd;
  logic [Bits-1:0]  r_ex_imm;
  logic [CNT_W-1:0] r_bubble_cnt;

  load_use_detect #(.IDX_W(IDX_W)) u_load_use_detect (
    .i_if_valid    (bus.if_valid),
    .i_if_rs1      (bus.if_rs1),
    .i_if_rs2      (bus.if_rs2),
    .i_if_use_rs2  (bus.if_use_rs2),
    .i_ex_valid    (r_ex_valid),
    .i_ex_mem_read (r_ex_ctrl.mem_read),
    .i_ex_rd       (r_ex_rd),
    .o_load_use    (w_load_use)
  );

  assign bus.rf_ptr_rd_1 = bus.if_rs1;
  assign bus.rf_ptr_rd_2 = bus.if_rs2;

  // Flush wins: the instruction in ID is dead, so there is nothing to hold.
  assign bus.id_stall = (w_load_use || bus.ex_hold) && !bus.flush;

  // Write-through bypass: the bank reads the old value during the cycle
  // it is being written, so take the WB data directly.
  always_comb begin
    w_op1 = bus.rf_data_rd_1;
    w_op2 = bus.rf_data_rd_2;
    if (bus.if_rs1 == '0)
      w_op1 = '0;
    else if (bus.wb_wr_en && (bus.wb_ptr_wr == bus.if_rs1))
      w_op1 = bus.wb_data_wr;
    if (bus.if_rs2 == '0)
      w_op2 = '0;
    else if (bus.wb_wr_en && (bus.wb_ptr_wr == bus.if_rs2))
      w_op2 = bus.wb_data_wr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_ctrl     <= CTRL_NOP;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_imm      <= '0;
      r_bubble_cnt  <= '0;
    end else if (bus.flush) begin
      // Data fields are left as-is; only the valid/control kill matters.
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= CTRL_NOP;
    end else if (bus.ex_hold) begin
      r_ex_valid <= r_ex_valid;
    end else if (w_load_use) begin
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= CTRL_NOP;
      if (r_bubble_cnt != '1)
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end else begin
      r_ex_valid    <= bus.if_valid;
      r_ex_ctrl     <= bus.if_valid ? bus.if_ctrl : CTRL_NOP;
      r_ex_rs1_data <= w_op1;
      r_ex_rs2_data <= w_op2;
      r_ex_rs1      <= bus.if_rs1;
      r_ex_rs2      <= bus.if_rs2;
      r_ex_rd       <= bus.if_rd;
      r_ex_imm      <= bus.if_imm;
    end
  end

  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_ctrl     = r_ex_ctrl;
  assign bus.ex_rs1_data = r_ex_rs1_data;
  assign bus.ex_rs2_data = r_ex_rs2_data;
  assign bus.ex_rs1      = r_ex_rs1;
  assign bus.ex_rs2      = r_ex_rs2;
  assign bus.ex_rd       = r_ex_rd;
  assign bus.ex_imm      = r_ex_imm;
  assign bus.bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage. The counter width is narrowed to 8 bits so the
// saturation scenario fits in a few hundred cycles.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int N       = 32;
  localparam int BITS    = 64;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = $clog2(N);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.N(N), .Bits(BITS), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.N(N), .Bits(BITS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Abstract view of the ID/EX slot: what execute should see next.
  logic             m_valid;
  logic [7:0]       m_ctrl;
  logic [BITS-1:0]  m_d1, m_d2, m_imm;
  logic [IDX_W-1:0] m_rs1, m_rs2, m_rd;
  int               m_cnt;
  logic [BITS-1:0]  exp_q[$];

  function automatic logic [BITS-1:0] op_sel(input logic [IDX_W-1:0] idx,
                                             input logic [BITS-1:0] rf);
    if (idx == 0) return '0;
    if (bus.wb_wr_en && bus.wb_ptr_wr == idx) return bus.wb_data_wr;
    return rf;
  endfunction

  // Depends on a load still in flight whose result is not yet available.
  function automatic logic model_lu();
    return bus.if_valid && m_valid && m_ctrl[CTRL_MEM_READ] && m_rd != 0 &&
           (m_rd == bus.if_rs1 || (bus.if_use_rs2 && m_rd == bus.if_rs2));
  endfunction

  function automatic logic model_stall();
    return (model_lu() || bus.ex_hold) && !bus.flush;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ctrl = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  // Advance one clock; model sees the inputs as they stood before the edge.
  task automatic tick();
    logic lu;
    logic [BITS-1:0] o1, o2;
    lu = model_lu();
    o1 = op_sel(bus.if_rs1, bus.rf_data_rd_1);
    o2 = op_sel(bus.if_rs2, bus.rf_data_rd_2);
    @(posedge clk);
    if (bus.flush) begin
      m_valid = 0; m_ctrl = 0;
    end else if (bus.ex_hold) begin
      m_valid = m_valid;
    end else if (lu) begin
      m_valid = 0; m_ctrl = 0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_valid = bus.if_valid;
      m_ctrl  = bus.if_valid ? 8'(bus.if_ctrl) : 8'h00;
      m_d1 = o1; m_d2 = o2; m_imm = bus.if_imm;
      m_rs1 = bus.if_rs1; m_rs2 = bus.if_rs2; m_rd = bus.if_rd;
      if (bus.if_valid) exp_q.push_back(o1);
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_instr(input logic v, input int rs1, input int rs2,
                             input int rd, input logic use2,
                             input logic [7:0] ctrl);
    bus.if_valid     = v;
    bus.if_rs1       = IDX_W'(rs1);
    bus.if_rs2       = IDX_W'(rs2);
    bus.if_rd        = IDX_W'(rd);
    bus.if_use_rs2   = use2;
    bus.if_imm       = {$urandom, $urandom};
    bus.if_ctrl      = ctrl_t'(ctrl);
    bus.rf_data_rd_1 = {$urandom, $urandom};
    bus.rf_data_rd_2 = {$urandom, $urandom};
    bus.wb_wr_en     = 0;
    bus.wb_ptr_wr    = 0;
    bus.wb_data_wr   = 0;
    bus.flush        = 0;
    bus.ex_hold      = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_instr(1, 1, 2, 4, 1, 8'h11);
    tick();
    #2 rst = 1;
    #1;
    model_reset();
    n_vec++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00 || bus.bubble_cnt !== '0 ||
        bus.ex_rs1_data !== '0 || bus.ex_rs2_data !== '0 || bus.ex_imm !== '0 ||
        bus.ex_rs1 !== '0 || bus.ex_rs2 !== '0 || bus.ex_rd !== '0) begin
      n_err++;
      $display("FAIL reset_clear: valid=%b ctrl=%h cnt=%h d1=%h imm=%h rd=%0d, required all 0",
               bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt, bus.ex_rs1_data, bus.ex_imm, bus.ex_rd);
    end
    #3 rst = 0;
    drive_instr(1, 5, 0, 6, 0, 8'h01);
    bus.rf_data_rd_1 = 64'h11;
    #1;
    n_vec++;
    if (bus.id_stall !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: got %b required 0", bus.id_stall);
    end
    tick();
    n_vec++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rs1_data !== 64'h11) begin
      n_err++;
      $display("FAIL reset_first_issue: valid=%b d1=%h, required 1 / 11", bus.ex_valid, bus.ex_rs1_data);
    end
  endtask

  task automatic test_bypass();
    drive_instr(1, 7, 9, 1, 1, 8'h01);
    bus.rf_data_rd_1 = 64'hAA;
    bus.wb_wr_en = 1; bus.wb_ptr_wr = 7; bus.wb_data_wr = 64'hBB;
    tick();
    n_vec++;
    if (bus.ex_rs1_data !== 64'hBB || bus.ex_rs2_data !== m_d2) begin
      n_err++;
      $display("FAIL bypass_hit: d1=%h d2=%h, required bb / %h", bus.ex_rs1_data, bus.ex_rs2_data, m_d2);
    end
    drive_instr(1, 0, 0, 1, 1, 8'h01);
    bus.rf_data_rd_1 = 64'hAA; bus.rf_data_rd_2 = 64'hAA;
    bus.wb_wr_en = 1; bus.wb_ptr_wr = 0; bus.wb_data_wr = 64'hBB;
    tick();
    n_vec++;
    if (bus.ex_rs1_data !== 64'h0 || bus.ex_rs2_data !== 64'h0) begin
      n_err++;
      $display("FAIL bypass_x0: d1=%h d2=%h, required 0 / 0", bus.ex_rs1_data, bus.ex_rs2_data);
    end
  endtask

  task automatic test_load_use();
    int cnt0;
    cnt0 = m_cnt;
    drive_instr(1, 1, 2, 3, 0, 8'h03);   // ld x3
    tick();
    drive_instr(1, 4, 3, 8, 1, 8'h01);   // add x8, x4, x3
    #1;
    n_vec++;
    if (bus.id_stall !== 1'b1) begin
      n_err++; $display("FAIL lu_stall: got %b required 1", bus.id_stall);
    end
    tick();
    n_vec++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00 || bus.bubble_cnt !== CNT_W'(cnt0 + 1)) begin
      n_err++;
      $display("FAIL lu_bubble: valid=%b ctrl=%h cnt=%0d, required 0 / 00 / %0d",
               bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt, cnt0 + 1);
    end
    n_vec++;
    if (bus.id_stall !== 1'b0) begin
      n_err++; $display("FAIL lu_stall_release: got %b required 0", bus.id_stall);
    end
    tick();
    n_vec++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd !== IDX_W'(8) || bus.ex_ctrl !== 8'h01) begin
      n_err++;
      $display("FAIL lu_issue: valid=%b rd=%0d ctrl=%h, required 1 / 8 / 01", bus.ex_valid, bus.ex_rd, bus.ex_ctrl);
    end
    drive_instr(1, 1, 2, 3, 0, 8'h03);
    tick();
    drive_instr(1, 4, 3, 9, 0, 8'h19);   // addi: rs2 field is not a source
    #1;
    n_vec++;
    if (bus.id_stall !== 1'b0) begin
      n_err++; $display("FAIL lu_no_rs2: got %b required 0", bus.id_stall);
    end
    tick();
    n_vec++;
    if (bus.ex_valid !== 1'b1 || bus.bubble_cnt !== CNT_W'(cnt0 + 1)) begin
      n_err++;
      $display("FAIL lu_no_rs2_issue: valid=%b cnt=%0d, required 1 / %0d", bus.ex_valid, bus.bubble_cnt, cnt0 + 1);
    end
  endtask

  task automatic test_flush_hold();
    logic [BITS-1:0] imm_x;
    drive_instr(1, 10, 11, 12, 1, 8'h35);
    imm_x = bus.if_imm;
    tick();
    drive_instr(1, 13, 14, 15, 1, 8'h01);
    bus.ex_hold = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (bus.id_stall !== 1'b1) begin
        n_err++; $display("FAIL hold_stall[%0d]: got %b required 1", c, bus.id_stall);
      end
      tick();
      n_vec++;
      if (bus.ex_valid !== 1'b1 || bus.ex_rd !== IDX_W'(12) || bus.ex_imm !== imm_x || bus.ex_ctrl !== 8'h35) begin
        n_err++;
        $display("FAIL hold_frozen[%0d]: valid=%b rd=%0d ctrl=%h, required 1 / 12 / 35",
                 c, bus.ex_valid, bus.ex_rd, bus.ex_ctrl);
      end
    end
    bus.flush = 1;
    #1;
    n_vec++;
    if (bus.id_stall !== 1'b0) begin
      n_err++; $display("FAIL flush_stall: got %b required 0", bus.id_stall);
    end
    tick();
    n_vec++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00) begin
      n_err++;
      $display("FAIL flush_kill: valid=%b ctrl=%h, required 0 / 00", bus.ex_valid, bus.ex_ctrl);
    end
  endtask

  task automatic test_load_x0();
    int cnt0;
    cnt0 = m_cnt;
    drive_instr(1, 1, 2, 0, 0, 8'h03);   // ld x0
    tick();
    drive_instr(1, 0, 0, 5, 1, 8'h01);
    #1;
    n_vec++;
    if (bus.id_stall !== 1'b0) begin
      n_err++; $display("FAIL x0_stall: got %b required 0", bus.id_stall);
    end
    tick();
    n_vec++;
    if (bus.ex_valid !== 1'b1 || bus.bubble_cnt !== CNT_W'(cnt0)) begin
      n_err++;
      $display("FAIL x0_issue: valid=%b cnt=%0d, required 1 / %0d", bus.ex_valid, bus.bubble_cnt, cnt0);
    end
  endtask

  // Randomised mix; full-slot compare after every edge.
  task automatic test_random();
    logic [BITS-1:0] exp_d1;
    for (int c = 0; c < 400; c++) begin
      if (!model_stall())
        drive_instr($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 1),
                    8'($urandom) & 8'hF9 | ($urandom_range(0, 9) < 4 ? 8'h02 : 8'h00));
      bus.rf_data_rd_1 = {$urandom, $urandom};
      bus.rf_data_rd_2 = {$urandom, $urandom};
      bus.wb_wr_en     = $urandom_range(0, 1);
      bus.wb_ptr_wr    = IDX_W'($urandom_range(0, 3));
      bus.wb_data_wr   = {$urandom, $urandom};
      bus.flush        = $urandom_range(0, 9) == 0;
      bus.ex_hold      = $urandom_range(0, 6) == 0;
      #1;
      n_vec++;
      if (bus.id_stall !== model_stall() || bus.rf_ptr_rd_1 !== bus.if_rs1 || bus.rf_ptr_rd_2 !== bus.if_rs2) begin
        n_err++;
        $display("FAIL rnd_comb[%0d]: stall=%b ptr1=%0d ptr2=%0d, required %b / %0d / %0d",
                 c, bus.id_stall, bus.rf_ptr_rd_1, bus.rf_ptr_rd_2, model_stall(), bus.if_rs1, bus.if_rs2);
      end
      exp_q.delete();
      tick();
      n_vec++;
      if (bus.ex_valid !== m_valid || bus.ex_ctrl !== m_ctrl || bus.bubble_cnt !== CNT_W'(m_cnt)) begin
        n_err++;
        $display("FAIL rnd_ctl[%0d]: valid=%b ctrl=%h cnt=%0d, required %b / %h / %0d",
                 c, bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt, m_valid, m_ctrl, m_cnt);
      end
      if (exp_q.size() != 0) begin
        exp_d1 = exp_q.pop_front();
        n_vec++;
        if (bus.ex_rs1_data !== exp_d1 || bus.ex_rs2_data !== m_d2 || bus.ex_imm !== m_imm ||
            bus.ex_rs1 !== m_rs1 || bus.ex_rs2 !== m_rs2 || bus.ex_rd !== m_rd) begin
          n_err++;
          $display("FAIL rnd_data[%0d]: d1=%h d2=%h rd=%0d, required %h / %h / %0d",
                   c, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_rd, exp_d1, m_d2, m_rd);
        end
      end
    end
  endtask

  // Same load re-issuing on its own destination: one bubble per two cycles.
  task automatic test_saturation();
    drive_instr(1, 5, 0, 5, 0, 8'h03);
    for (int c = 0; c < 2 * (CNT_MAX + 3) + 2; c++) tick();
    n_vec++;
    if (bus.bubble_cnt !== CNT_W'(CNT_MAX) || m_cnt != CNT_MAX) begin
      n_err++;
      $display("FAIL sat_reach: got %0d required %0d", bus.bubble_cnt, CNT_MAX);
    end
    for (int c = 0; c < 6; c++) tick();
    n_vec++;
    if (bus.bubble_cnt !== CNT_W'(CNT_MAX)) begin
      n_err++;
      $display("FAIL sat_hold: got %0d required %0d", bus.bubble_cnt, CNT_MAX);
    end
  endtask

  initial begin
    rst = 1;
    model_reset();
    drive_instr(0, 0, 0, 0, 0, 8'h00);
    #12 rst = 0;
    @(negedge clk);
    n_vec++;
    if (bus.ex_valid !== 1'b0 || bus.bubble_cnt !== '0 || bus.id_stall !== 1'b0) begin
      n_err++;
      $display("FAIL power_on: valid=%b cnt=%0d stall=%b, required 0 / 0 / 0",
               bus.ex_valid, bus.bubble_cnt, bus.id_stall);
    end
    test_reset();
    test_bypass();
    test_load_use();
    test_flush_hold();
    test_load_x0();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
